// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between the L1 I-cache and D-cache.
// A grant latches the winning request and replays it to the L2 until l2_resp.

module l2_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              l2_read,
    output logic              l2_write,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [LINE_W-1:0] l2_wdata,
    input  logic [LINE_W-1:0] l2_rdata,
    input  logic              l2_resp,
    output logic [1:0]        owner
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_I,
        SERVE_D,
        RESP_I,
        RESP_D
    } state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    state_e            state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
    logic [LINE_W-1:0] d_rdata_q, d_rdata_d;

    logic req_i;
    logic req_d;
    logic serving;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            IDLE: begin
                // I wins when alone, or on a tie when D had the previous grant.
                if (req_i && (!req_d || last_grant_q == GRANT_D)) begin
                    state_d      = SERVE_I;
                    addr_d       = i_addr;
                    write_d      = 1'b0;
                    last_grant_d = GRANT_I;
                end else if (req_d) begin
                    state_d      = SERVE_D;
                    addr_d       = d_addr;
                    wdata_d      = d_wdata;
                    write_d      = d_write;
                    last_grant_d = GRANT_D;
                end
            end
            SERVE_I: begin
                if (l2_resp) begin
                    i_rdata_d = l2_rdata;
                    state_d   = RESP_I;
                end
            end
            SERVE_D: begin
                if (l2_resp) begin
                    if (!write_q) begin
                        d_rdata_d = l2_rdata;
                    end
                    state_d = RESP_D;
                end
            end
            RESP_I:  state_d = IDLE;
            RESP_D:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_D;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // All L2-facing outputs come from latched state, so requester changes never reach the L2.
    assign serving  = (state_q == SERVE_I) || (state_q == SERVE_D);
    assign l2_read  = (state_q == SERVE_I) || ((state_q == SERVE_D) && !write_q);
    assign l2_write = (state_q == SERVE_D) && write_q;
    assign l2_addr  = serving ? addr_q : '0;
    assign l2_wdata = l2_write ? wdata_q : '0;

    assign i_resp  = (state_q == RESP_I);
    assign d_resp  = (state_q == RESP_D);
    assign i_rdata = i_rdata_q;
    assign d_rdata = d_rdata_q;

    always_comb begin
        owner = 2'b00;
        if (state_q == SERVE_I || state_q == RESP_I) begin
            owner = 2'b01;
        end else if (state_q == SERVE_D || state_q == RESP_D) begin
            owner = 2'b10;
        end
    end

    a_l2_strobe_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(l2_read && l2_write));

    a_resp_excl: assert property (@(posedge clk) disable iff (!rst_n)
        !(i_resp && d_resp));

    a_serve_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (serving && state_d == state_q) |=> ($stable(l2_addr) && $stable(l2_wdata)));

endmodule
